// File: rtl/tdm_pkg.sv
// Shared definitions for the two-channel TDM demultiplexer.
// Holds the framing FSM state type, the default sample width and the
// error-counter width used when DEMUX_ERRCNT_EN is defined.
package tdm_pkg;

  // Framing FSM states; encoding 2'd3 is unused and recovers to ST_HUNT.
  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_EXP_B = 2'd1,
    ST_EXP_A = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_DW = 8;
  localparam int unsigned ERRCNT_W   = 8;

endpackage

// File: rtl/tdm_demux_sat_counter.sv
// Width-parameterised saturating up-counter with asynchronous active-high
// reset. Counts one per cycle with inc high and holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count up on inc, stick at the maximum value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// Two-channel TDM demultiplexer. Locks onto an alternating A/B word stream
// (A marked by in_sof) and presents each complete frame as a registered
// out_a/out_b pair with a one-cycle out_valid strobe.
// Optional feature: define DEMUX_ERRCNT_EN to add the saturating err_count
// output that counts frame_err pulses.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int unsigned DW = DEFAULT_DW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [DW-1:0]       in_data,
  input  logic                in_sof,
  output logic [DW-1:0]       out_a,
  output logic [DW-1:0]       out_b,
  output logic                out_valid,
  output logic                locked,
  output logic                frame_err
`ifdef DEMUX_ERRCNT_EN
  ,
  output logic [ERRCNT_W-1:0] err_count
`endif
);

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] shadow;
  logic          shadow_ld;
  logic          pair_ld;
  logic          err;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and per-word actions; idle cycles change nothing.
  always_comb begin
    state_nxt = state;
    shadow_ld = 1'b0;
    pair_ld   = 1'b0;
    err       = 1'b0;
    if (in_valid) begin
      case (state)
        ST_HUNT: begin
          if (in_sof) begin
            shadow_ld = 1'b1;
            state_nxt = ST_EXP_B;
          end
        end
        ST_EXP_B: begin
          if (in_sof) begin
            // Resync onto the newer frame start.
            err       = 1'b1;
            shadow_ld = 1'b1;
          end else begin
            pair_ld   = 1'b1;
            state_nxt = ST_EXP_A;
          end
        end
        ST_EXP_A: begin
          if (in_sof) begin
            shadow_ld = 1'b1;
            state_nxt = ST_EXP_B;
          end else begin
            err       = 1'b1;
            state_nxt = ST_HUNT;
          end
        end
        default: begin
          state_nxt = ST_HUNT;
        end
      endcase
    end
  end

  // Registered outputs, A shadow and lock flag.
  // locked is loaded from the next state so it tracks the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow    <= '0;
      out_a     <= '0;
      out_b     <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      locked    <= 1'b0;
    end else begin
      out_valid <= pair_ld;
      frame_err <= err;
      locked    <= (state_nxt == ST_EXP_B) || (state_nxt == ST_EXP_A);
      if (shadow_ld) begin
        shadow <= in_data;
      end
      if (pair_ld) begin
        out_a <= shadow;
        out_b <= in_data;
      end
    end
  end

`ifdef DEMUX_ERRCNT_EN
  // Counts the same event that raises frame_err, so both update together.
  sat_counter #(
    .W(ERRCNT_W)
  ) u_errcnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (err),
    .count(err_count)
  );
`endif

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: directed frames, resync cases, reset and
// randomized traffic against a queue-based frame model.
module tb_tdm_demux;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_sof = 1'b0;
  logic [DW-1:0] out_a, out_b;
  logic          out_valid, locked, frame_err;
`ifdef DEMUX_ERRCNT_EN
  logic [7:0]    err_count;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: pending A samples awaiting their B, plus lock flag.
  logic [DW-1:0] pend[$];
  bit            m_locked;
  logic [DW-1:0] ea, eb;
  bit            ev, ee;
  int            ecnt;

  tdm_demux #(.DW(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_sof   (in_sof),
    .out_a    (out_a),
    .out_b    (out_b),
    .out_valid(out_valid),
    .locked   (locked),
    .frame_err(frame_err)
`ifdef DEMUX_ERRCNT_EN
    ,
    .err_count(err_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    pend.delete();
    m_locked = 0;
    ea = '0; eb = '0; ev = 0; ee = 0; ecnt = 0;
  endtask

  // Apply one cycle of input, then advance the model to what must be visible.
  task automatic drive(input bit v, input bit s, input logic [DW-1:0] d);
    @(negedge clk);
    in_valid = v; in_sof = s; in_data = d;
    @(posedge clk);
    #1;
    ev = 0; ee = 0;
    if (v) begin
      if (s) begin
        if (pend.size() != 0) begin
          ee = 1;
          pend.delete();
        end
        pend.push_back(d);
        m_locked = 1;
      end else if (pend.size() != 0) begin
        ea = pend.pop_front();
        eb = d;
        ev = 1;
      end else if (m_locked) begin
        ee = 1;
        m_locked = 0;
      end
    end
    if (ee && ecnt < 255) ecnt++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; in_valid = 0; in_sof = 0; in_data = '0;
    repeat (2) @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1; in_valid = 0;
    #1;
    model_reset();
    checks++;
    if ({out_valid, frame_err, locked, out_a, out_b} !== '0) begin
      errors++;
      $display("FAIL reset: got v=%0b e=%0b l=%0b a=%h b=%h want all 0",
               out_valid, frame_err, locked, out_a, out_b);
    end
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_directed(input string name, input int n,
                               input logic [DW:0] tbl[16]);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, tbl[i][DW], tbl[i][DW-1:0]);
      checks++;
      if ({out_valid, frame_err, locked, out_a, out_b} !==
          {ev, ee, m_locked, ea, eb}) begin
        errors++;
        $display("FAIL %s[%0d]: got v=%0b e=%0b l=%0b a=%h b=%h want v=%0b e=%0b l=%0b a=%h b=%h",
                 name, i, out_valid, frame_err, locked, out_a, out_b,
                 ev, ee, m_locked, ea, eb);
      end
    end
  endtask

  task automatic test_clean();
    logic [DW:0] t[16];
    t[0] = {1'b1, 8'h11}; t[1] = {1'b0, 8'h22};
    t[2] = {1'b1, 8'h33}; t[3] = {1'b0, 8'h44};
    do_reset();
    test_directed("clean", 4, t);
  endtask

  task automatic test_hunt();
    logic [DW:0] t[16];
    t[0] = {1'b0, 8'h10}; t[1] = {1'b0, 8'h20}; t[2] = {1'b0, 8'h30};
    t[3] = {1'b1, 8'hA5}; t[4] = {1'b0, 8'h5A};
    do_reset();
    test_directed("hunt", 5, t);
  endtask

  task automatic test_double_sof();
    logic [DW:0] t[16];
    t[0] = {1'b1, 8'h01}; t[1] = {1'b1, 8'h02}; t[2] = {1'b0, 8'h03};
    do_reset();
    test_directed("double_sof", 3, t);
  endtask

  task automatic test_missing_sof();
    logic [DW:0] t[16];
    t[0] = {1'b1, 8'h66}; t[1] = {1'b0, 8'h67}; t[2] = {1'b0, 8'h77};
    t[3] = {1'b0, 8'h78};
    do_reset();
    test_directed("missing_sof", 4, t);
  endtask

  task automatic test_gaps();
    do_reset();
    drive(1'b1, 1'b1, 8'hC0);
    for (int i = 0; i < 6; i++) begin
      if (i < 5) drive(1'b0, 1'($urandom), DW'($urandom));
      else drive(1'b1, 1'b0, 8'hC1);
      checks++;
      if ({out_valid, frame_err, locked, out_a, out_b} !==
          {ev, ee, m_locked, ea, eb}) begin
        errors++;
        $display("FAIL gaps[%0d]: got v=%0b e=%0b l=%0b a=%h b=%h want v=%0b e=%0b l=%0b a=%h b=%h",
                 i, out_valid, frame_err, locked, out_a, out_b,
                 ev, ee, m_locked, ea, eb);
      end
    end
  endtask

  task automatic test_reset_midframe();
    do_reset();
    drive(1'b1, 1'b1, 8'h3C);
    drive(1'b1, 1'b0, 8'h3D);
    drive(1'b1, 1'b1, 8'h4E);
    @(negedge clk);
    in_valid = 0;
    #2 rst = 1;
    #1;
    checks++;
    if ({out_valid, frame_err, locked, out_a, out_b} !== '0) begin
      errors++;
      $display("FAIL reset_midframe: got v=%0b e=%0b l=%0b a=%h b=%h want all 0",
               out_valid, frame_err, locked, out_a, out_b);
    end
    @(negedge clk);
    rst = 0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 8'h50 + 8'(i));
      checks++;
      if ({out_valid, frame_err, locked, out_a, out_b} !== '0) begin
        errors++;
        $display("FAIL post_reset[%0d]: got v=%0b e=%0b l=%0b a=%h b=%h want all 0",
                 i, out_valid, frame_err, locked, out_a, out_b);
      end
    end
  endtask

  task automatic test_random();
    bit s, v;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = (pend.size() == 0);
      if ($urandom_range(0, 9) == 0) s = !s;
      drive(v, s, DW'($urandom));
      checks++;
      if ({out_valid, frame_err, locked, out_a, out_b} !==
          {ev, ee, m_locked, ea, eb}) begin
        errors++;
        $display("FAIL random[%0d]: got v=%0b e=%0b l=%0b a=%h b=%h want v=%0b e=%0b l=%0b a=%h b=%h",
                 i, out_valid, frame_err, locked, out_a, out_b,
                 ev, ee, m_locked, ea, eb);
      end
    end
  endtask

`ifdef DEMUX_ERRCNT_EN
  task automatic test_errcnt();
    do_reset();
    drive(1'b1, 1'b1, 8'h90);
    drive(1'b1, 1'b0, 8'h91);
    for (int i = 0; i < 300 + 261; i++) begin
      if (i < 300) drive(1'b1, 1'b0, DW'($urandom));
      else drive(1'b1, 1'b1, DW'($urandom));
      checks++;
      if ({frame_err, locked, err_count} !== {ee, m_locked, 8'(ecnt)}) begin
        errors++;
        $display("FAIL errcnt[%0d]: got e=%0b l=%0b cnt=%0d want e=%0b l=%0b cnt=%0d",
                 i, frame_err, locked, err_count, ee, m_locked, ecnt);
      end
    end
  endtask
`endif

  initial begin
    model_reset();
    test_reset();
    test_clean();
    test_hunt();
    test_double_sof();
    test_missing_sof();
    test_gaps();
    test_reset_midframe();
    test_random();
`ifdef DEMUX_ERRCNT_EN
    test_errcnt();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tdm_demux.md
# tdm_demux

Two-channel time-division demultiplexer: the receive-side counterpart of the 2:1 select mux. It takes a single word stream in which channel-A and channel-B samples alternate, with A marked by a start-of-frame flag. It locks onto that framing and presents each A/B pair as a coherent registered output pair with a one-cycle valid strobe. The block sits downstream of a link that was fed by a sel-driven mux, and restores the two original lanes.

## Interface
Parameters:
- DW, 8, sample width in bits (≥1)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data/in_sof qualify this cycle
- in_data  input  DW  sample word
- in_sof  input  1  high on the channel-A slot of each frame
- out_a  output  DW  last complete frame's channel-A sample
- out_b  output  DW  last complete frame's channel-B sample
- out_valid  output  1  one-cycle pulse: new out_a/out_b pair
- locked  output  1  framing acquired
- frame_err  output  1  one-cycle pulse on framing violation

## Operation
- Reset (asynchronous, immediate):
  - out_a=0, out_b=0, out_valid=0, locked=0, frame_err=0.
  - Internal A shadow register = 0.
  - State = HUNT.
- FSM states: HUNT, EXP_B, EXP_A. Transitions happen only on cycles with in_valid=1. in_valid=0 holds state and all registers, and out_valid/frame_err deassert.
- HUNT:
  - sof=1: capture in_data into A shadow; go to EXP_B.
  - sof=0: discard the word; stay in HUNT.
- EXP_B:
  - sof=0: load out_a←shadow and out_b←in_data together; pulse out_valid; go to EXP_A.
  - sof=1: pulse frame_err; overwrite shadow with in_data; stay in EXP_B (resync on the new frame).
- EXP_A:
  - sof=1: capture the shadow; go to EXP_B.
  - sof=0: pulse frame_err; discard the word; go to HUNT.
- locked = 1 in EXP_B or EXP_A, 0 in HUNT. locked is registered and follows the state register.
- out_a/out_b change only together, and only on out_valid cycles. Between pulses they hold the last good pair. An incomplete frame never updates them.
- Data is passed through unmodified. There is no arithmetic, and widths are DW throughout.

## Timing
- All outputs are registered. No combinational path from any input to any output.
- Latency: the B sample accepted at edge N appears on out_b with out_valid=1 during cycle N+1, i.e. immediately after edge N.
- frame_err asserts for exactly the one cycle following the offending edge.
- Peak throughput is one pair every two in_valid cycles. Gaps (in_valid=0) between the A and B slots of a frame are allowed and of unbounded length.
- Reset asserted mid-frame:
  - The pending A sample is dropped.
  - No out_valid is issued for the partial frame.
  - After release, the first frame needs a fresh sof.

## Configuration
- DEMUX_ERRCNT_EN defined:
  - Adds output port err_count [7:0], reset to 0.
  - err_count increments on every frame_err pulse and saturates at 255 (holds at 255).
- DEMUX_ERRCNT_EN undefined: the port and its counter are absent, and all other behaviour is identical.

## Structure
- Shared package (tdm_pkg):
  - state encoding constants ST_HUNT=2'd0, ST_EXP_B=2'd1, ST_EXP_A=2'd2
  - default DW=8
  - ERRCNT_W=8
- Encoding 2'd3 is illegal. The FSM returns from it to HUNT on the next in_valid, without a frame_err pulse.
- Optional sub-module sat_counter (width-parameterised saturating up-counter with async active-high reset), instantiated only under DEMUX_ERRCNT_EN. Everything else is in the single tdm_demux module.

## Test plan
- Clean stream, DW=8: (sof=1, 0x11), (0, 0x22), (1, 0x33), (0, 0x44) back-to-back → out_valid pulses twice; pairs (0x11, 0x22) then (0x33, 0x44); locked=1 from the cycle after the first word; frame_err never asserts.
- Hunt: three sof=0 words then (1, 0xA5), (0, 0x5A) → no outputs during the first three words; locked rises after 0xA5; one pair (0xA5, 0x5A).
- Double sof: (1, 0x01), (1, 0x02), (0, 0x03) → one frame_err pulse; pair (0x02, 0x03); 0x01 never appears on out_a.
- Missing sof: valid frame, then (0, 0x77) in EXP_A → frame_err pulse; locked=0; out_a/out_b hold the previous pair.
- Gaps and reset: (1, 0xC0), 5 idle cycles, (0, 0xC1) → pair (0xC0, 0xC1). Separately, rst asserted between the A and B slots → all outputs 0 at once, no out_valid after release.
- With DEMUX_ERRCNT_EN: 300 consecutive sof=0 words while locked, preceded by one good frame → err_count=1 after the first error; HUNT discards the rest with no further pulses. Then force 260 alternating double-sof errors → err_count saturates at 255.
